act_unit: RTL and testbench
===========================

# act_unit

Multi-channel, mode-selectable activation stage for the CNN datapath. It is the parametrised successor to the single-lane sigmoid stage and sits between the convolution/accumulate output and the pooling/writeback stage. It applies one of four activations to CH fixed-point lanes per beat. It uses a 2-stage pipeline with valid/ready backpressure.

## Interface
- DATA_WIDTH, 32: lane width, signed two's complement.
- FRAC_BITS, 16: fractional bits; 1.0 = 1<<FRAC_BITS.
- CH, 4: lanes per beat (1..16).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  accept from upstream; equals !o_valid || i_ready.
- i_mode  in  2  activation select, sampled with the beat: 0 bypass, 1 ReLU, 2 leaky ReLU, 3 sigmoid.
- i_data  in  CH*DATA_WIDTH  lane k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_valid  out  1  result beat valid.
- i_ready  in  1  downstream accept.
- o_data  out  CH*DATA_WIDTH  results, same packing.
- i_clr  in  1  synchronous clear of o_sat_cnt (ACT_SAT_CNT_EN only).
- o_sat_cnt  out  16  saturation event count (ACT_SAT_CNT_EN only).

## Operation
- Beat transfer in: i_valid && o_ready. Beat transfer out: o_valid && i_ready.
- Stage 1 registers the following: mode, sign, |x|, and the sigmoid segment index per lane.
  - |x| of the most-negative input saturates to the max positive value.
- Stage 2 registers the result per lane:
  - Bypass: y = x.
  - ReLU: y = x<0 ? 0 : x.
  - Leaky: y = x<0 ? x>>>3 (arithmetic shift, rounds toward -inf) : x.
  - Sigmoid (PLAN, shift-add only, on a = |x|):
    - a >= 5.0: p = 1.0
    - 2.375 <= a < 5.0: p = (a>>5) + 0.84375
    - 1.0 <= a < 2.375: p = (a>>3) + 0.625
    - a < 1.0: p = (a>>2) + 0.5
    - Then y = x<0 ? 1.0 - p : p. Shifts truncate.
- All lanes share one mode and one handshake. Lanes are independent datapaths.
- Mode values are decoded only at stage 1. A beat keeps its mode through the pipe.
- The pipeline uses a global stall. Both stages advance when adv = !o_valid || i_ready; otherwise everything holds.
- No bubbles when i_ready is held high: sustained throughput is 1 beat/cycle.

## Timing
- Latency: 2 cycles from input acceptance to o_valid with no stall.
- Reset values:
  - o_valid = 0, internal stage-1 valid = 0, o_data = 0, o_sat_cnt = 0.
  - o_ready = 1 after reset.
- While o_valid && !i_ready:
  - o_data and o_valid hold stable.
  - o_ready = 0, so no new beat is accepted.
- Simultaneous output accept and input accept in the same cycle: both beats advance. Nothing is lost or duplicated.
- An asserted rst_n mid-stream drops all in-flight beats immediately (asynchronous). No partial output is produced.
- i_data and i_mode are don't-care when i_valid = 0.

## Configuration
- ACT_SAT_CNT_EN defined:
  - o_sat_cnt increments by 1 per output-accepted beat if any lane in sigmoid mode had a >= 5.0.
  - The counter saturates at 0xFFFF.
  - i_clr has priority over increment, taking effect next cycle.
- Undefined: i_clr is ignored, o_sat_cnt is tied to 0, and no counter logic is generated.

## Structure
- Package act_pkg holds:
  - typedef enum logic [1:0] act_mode_e {ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_SIGMOID}.
  - Functions returning the PLAN breakpoints (1.0, 2.375, 5.0) and offsets (0.5, 0.625, 0.84375) scaled by FRAC_BITS.
  - Leaky shift constant LEAKY_SHIFT = 3.
- Sub-module act_lane: the single-lane 2-stage datapath, instantiated CH times via generate.
  - Each lane takes the shared advance enable and outputs a per-lane saturation flag.
- Handshake, valid pipeline and counter live in act_unit.

## Test plan
All values are in Q16.16, CH=4, with i_ready=1 unless stated.
- Sigmoid mode, lanes {0, 1.0, -1.0, 8.0} = {0x00000000, 0x00010000, 0xFFFF0000, 0x00080000}: expect {0x00008000, 0x0000C000, 0x00004000, 0x00010000} exactly 2 cycles later.
- ReLU and leaky on lane value -3.0 (0xFFFD0000) and 2.5 (0x00028000):
  - ReLU gives 0x00000000 and 0x00028000.
  - Leaky gives 0xFFFFA000 and 0x00028000.
  - Bypass on the same beat returns the input unchanged.
- Streaming 16 beats with alternating modes: 16 outputs in order, with matching modes per beat and no gaps.
- Backpressure: hold i_ready=0 for 5 cycles with i_valid=1.
  - Expect o_ready=0 after 2 beats fill the pipe, and o_data stable.
  - On release, all beats emerge in order with no loss or duplication.
- Assert rst_n low mid-stream with 2 beats in flight: o_valid drops to 0 immediately; after release, o_valid stays 0 until new input.
- ACT_SAT_CNT_EN defined:
  - 3 sigmoid beats with a lane at -6.0 give o_sat_cnt=3.
  - i_clr gives 0 next cycle.
  - Preload via 0xFFFF+2 events stays at 0xFFFF.

Source files
------------

// File: rtl/act_pkg.sv
// act_unit shared types and fixed-point constants.
// The piecewise-linear sigmoid breakpoints and offsets are scaled by FRAC_BITS.
package act_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS,
    ACT_RELU,
    ACT_LEAKY,
    ACT_SIGMOID
  } act_mode_e;

  typedef enum logic [1:0] {
    SEG_LO,
    SEG_MID,
    SEG_HI,
    SEG_SAT
  } act_seg_e;

  localparam int unsigned LEAKY_SHIFT = 3;

  // num / 2^sh in fixed point with fb fraction bits
  function automatic logic [63:0] fx(
    input int unsigned num,
    input int unsigned sh,
    input int unsigned fb
  );
    return (64'(num) << fb) >> sh;
  endfunction

  // breakpoints: 1.0, 2.375, 5.0
  function automatic logic [63:0] plan_brk(
    input int unsigned idx,
    input int unsigned fb
  );
    if (idx == 0) return fx(1, 0, fb);
    if (idx == 1) return fx(19, 3, fb);
    return fx(5, 0, fb);
  endfunction

  // offsets: 0.5, 0.625, 0.84375
  function automatic logic [63:0] plan_off(
    input int unsigned idx,
    input int unsigned fb
  );
    if (idx == 0) return fx(1, 1, fb);
    if (idx == 1) return fx(5, 3, fb);
    return fx(27, 5, fb);
  endfunction

endpackage

// File: rtl/act_if.sv
// act_unit stream interface: upstream beat in, result beat out.
// master drives beats and downstream ready; slave is the activation stage.
interface act_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CH         = 4
);

  logic                     i_valid;
  logic                     o_ready;
  logic [1:0]               i_mode;
  logic [CH*DATA_WIDTH-1:0] i_data;
  logic                     o_valid;
  logic                     i_ready;
  logic [CH*DATA_WIDTH-1:0] o_data;

  modport master (
    output i_valid,
    output i_mode,
    output i_data,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data
  );

  modport slave (
    input  i_valid,
    input  i_mode,
    input  i_data,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data
  );

endinterface

// File: rtl/act_unit_lane.sv
// act_lane: one lane of the 2-stage activation datapath.
// Stage 1 classifies the input, stage 2 forms the result.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adv,
  input  logic                  in_valid,
  input  logic                  mid_valid,
  input  act_mode_e             mode,
  input  logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  sat
);

  localparam int DW = DATA_WIDTH;

  localparam logic [DW-1:0] ONE  = DW'(plan_brk(0, FRAC_BITS));
  localparam logic [DW-1:0] BRK1 = DW'(plan_brk(1, FRAC_BITS));
  localparam logic [DW-1:0] BRK2 = DW'(plan_brk(2, FRAC_BITS));
  localparam logic [DW-1:0] OFF0 = DW'(plan_off(0, FRAC_BITS));
  localparam logic [DW-1:0] OFF1 = DW'(plan_off(1, FRAC_BITS));
  localparam logic [DW-1:0] OFF2 = DW'(plan_off(2, FRAC_BITS));

  localparam logic [DW-1:0] X_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] X_MIN = {1'b1, {(DW-1){1'b0}}};

  logic          neg_c;
  logic [DW-1:0] abs_c;
  act_seg_e      seg_c;

  always_comb begin
    neg_c = x[DW-1];
    abs_c = x;
    if (neg_c) abs_c = (x == X_MIN) ? X_MAX : -x;
    seg_c = SEG_LO;
    unique case (1'b1)
      (abs_c >= BRK2):                   seg_c = SEG_SAT;
      (abs_c >= BRK1 && abs_c < BRK2):   seg_c = SEG_HI;
      (abs_c >= ONE && abs_c < BRK1):    seg_c = SEG_MID;
      (abs_c < ONE):                     seg_c = SEG_LO;
    endcase
  end

  act_mode_e     mode1;
  logic          neg1;
  logic [DW-1:0] abs1;
  logic [DW-1:0] x1;
  act_seg_e      seg1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode1 <= ACT_BYPASS;
      neg1  <= 1'b0;
      abs1  <= '0;
      x1    <= '0;
      seg1  <= SEG_LO;
    end else if (adv && in_valid) begin
      mode1 <= mode;
      neg1  <= neg_c;
      abs1  <= abs_c;
      x1    <= x;
      seg1  <= seg_c;
    end
  end

  logic [DW-1:0] p;
  logic [DW-1:0] y_c;

  always_comb begin
    p = ONE;
    unique case (seg1)
      SEG_SAT: p = ONE;
      SEG_HI:  p = (abs1 >> 5) + OFF2;
      SEG_MID: p = (abs1 >> 3) + OFF1;
      SEG_LO:  p = (abs1 >> 2) + OFF0;
    endcase
    y_c = x1;
    unique case (mode1)
      ACT_BYPASS:  y_c = x1;
      ACT_RELU:    y_c = neg1 ? '0 : x1;
      ACT_LEAKY:   y_c = neg1 ? DW'($signed(x1) >>> LEAKY_SHIFT) : x1;
      ACT_SIGMOID: y_c = neg1 ? ONE - p : p;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (adv && mid_valid) begin
      y   <= y_c;
      sat <= (mode1 == ACT_SIGMOID) && (seg1 == SEG_SAT);
    end
  end

endmodule

// File: rtl/act_unit.sv
// act_unit: CH-lane activation stage, 2-deep pipe with global stall.
// Define ACT_SAT_CNT_EN to build the sigmoid saturation event counter.
module act_unit
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int CH         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  act_if.slave        bus,
  input  logic        i_clr,
  output logic [15:0] o_sat_cnt
);

  localparam int DW = DATA_WIDTH;

  logic          mid_valid;
  logic          out_valid;
  logic          adv;
  logic [CH-1:0] sat;
  logic [CH*DW-1:0] data_q;
  act_mode_e     mode;

  assign adv         = !out_valid || bus.i_ready;
  assign bus.o_ready = adv;
  assign bus.o_valid = out_valid;
  assign bus.o_data  = data_q;
  assign mode        = act_mode_e'(bus.i_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_valid <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      mid_valid <= bus.i_valid;
      out_valid <= mid_valid;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    act_lane #(
      .DATA_WIDTH (DW),
      .FRAC_BITS  (FRAC_BITS)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv),
      .in_valid  (bus.i_valid),
      .mid_valid (mid_valid),
      .mode      (mode),
      .x         (bus.i_data[k*DW +: DW]),
      .y         (data_q[k*DW +: DW]),
      .sat       (sat[k])
    );
  end

`ifdef ACT_SAT_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (out_valid && bus.i_ready && (|sat)
                 && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign o_sat_cnt = cnt;
`else
  logic unused_sat;
  assign unused_sat = ^{sat, i_clr};
  assign o_sat_cnt  = '0;
`endif

endmodule

// File: tb/tb_act_unit.sv
// Scoreboard bench for act_unit, CH=4, Q16.16.
// Counter checks follow ACT_SAT_CNT_EN.
module tb_act_unit;

  localparam int DW = 32;
  localparam int CH = 4;
  localparam int FB = 16;

  typedef logic [CH*DW-1:0] beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] sat_cnt;

  always #5 clk = ~clk;

  act_if #(.DATA_WIDTH(DW), .CH(CH)) bus ();

  act_unit #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB),
    .CH         (CH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .i_clr     (clr),
    .o_sat_cnt (sat_cnt)
  );

  beat_t sb[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    run_len = 0;
  int    max_run = 0;
  logic  acc;

  function automatic logic [31:0] ref_lane(logic [1:0] m, logic [31:0] x);
    longint xs, a, p;
    xs = longint'($signed(x));
    case (m)
      2'd0: return x;
      2'd1: return (xs < 0) ? 32'd0 : x;
      2'd2: return (xs < 0) ? 32'(-((-xs + 7) / 8)) : x;
      default: begin
        a = (xs < 0) ? -xs : xs;
        if (a > 2147483647) a = 2147483647;
        if (a >= 327680)      p = 65536;
        else if (a >= 155648) p = a / 32 + 55296;
        else if (a >= 65536)  p = a / 8 + 40960;
        else                  p = a / 4 + 32768;
        return (xs < 0) ? 32'(65536 - p) : 32'(p);
      end
    endcase
  endfunction

  function automatic beat_t ref_beat(logic [1:0] m, beat_t d);
    beat_t r;
    for (int k = 0; k < CH; k++) r[k*DW +: DW] = ref_lane(m, d[k*DW +: DW]);
    return r;
  endfunction

  // one clock: compare any output transfer, record any input transfer
  task automatic tick();
    beat_t e;
    @(negedge clk);
    if (rst_n && bus.o_valid && bus.i_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra got=%h exp=none", bus.o_data);
      end else begin
        e = sb.pop_front();
        if (bus.o_data !== e) begin
          n_fail++;
          $display("FAIL sb_data got=%h exp=%h", bus.o_data, e);
        end
      end
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    acc = rst_n && bus.i_valid && bus.o_ready;
    if (acc) sb.push_back(ref_beat(bus.i_mode, bus.i_data));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(logic [1:0] m, beat_t d);
    bus.i_valid = 1'b1;
    bus.i_mode  = m;
    bus.i_data  = d;
    acc = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (acc) break;
    end
    n_chk++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_timeout got=0 exp=1");
    end
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      if (sb.size() == 0) break;
      tick();
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_reset();
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_mode  = 2'd0;
    bus.i_data  = '0;
    #1 rst_n = 1'b0;
    #10;
    n_chk++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_valid got=%b exp=0", bus.o_valid);
    end
    n_chk++;
    if (bus.o_data !== '0) begin
      n_fail++; $display("FAIL rst_data got=%h exp=0", bus.o_data);
    end
    n_chk++;
    if (bus.o_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready got=%b exp=1", bus.o_ready);
    end
    n_chk++;
    if (sat_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_cnt got=%h exp=0", sat_cnt);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) tick();
    n_chk++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle got=%b exp=0", bus.o_valid);
    end
  endtask

  task automatic test_sigmoid();
    beat_t d, e;
    d = {32'h00080000, 32'hFFFF0000, 32'h00010000, 32'h00000000};
    e = {32'h00010000, 32'h00004000, 32'h0000C000, 32'h00008000};
    send(2'd3, d);
    idle();
    n_chk++;
    if (bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL sig_lat1 got=%b exp=0", bus.o_valid);
    end
    tick();
    n_chk++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== e) begin
      n_fail++;
      $display("FAIL sig_lat2 got=%b/%h exp=1/%h", bus.o_valid, bus.o_data, e);
    end
    drain();
  endtask

  task automatic test_modes();
    beat_t d;
    beat_t e[3];
    logic [1:0] m[3];
    d = {32'h00028000, 32'hFFFD0000, 32'h00028000, 32'hFFFD0000};
    m[0] = 2'd1;
    e[0] = {32'h00028000, 32'h00000000, 32'h00028000, 32'h00000000};
    m[1] = 2'd2;
    e[1] = {32'h00028000, 32'hFFFFA000, 32'h00028000, 32'hFFFFA000};
    m[2] = 2'd0;
    e[2] = d;
    for (int i = 0; i < 3; i++) begin
      send(m[i], d);
      idle();
      tick();
      n_chk++;
      if (bus.o_data !== e[i]) begin
        n_fail++;
        $display("FAIL mode%0d got=%h exp=%h", m[i], bus.o_data, e[i]);
      end
      drain();
    end
    // breakpoint edges and most-negative input
    send(2'd3, {32'hFFFDA000, 32'h0004FFFF, 32'h00050000, 32'h80000000});
    send(2'd3, {32'h0000FFFF, 32'h00025FFF, 32'h00026000, 32'h7FFFFFFF});
    send(2'd0, {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF9, 32'h00000001});
    send(2'd2, {32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF8, 32'hFFFFFFFF});
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] bnd[12];
    beat_t d;
    int c0;
    bnd = '{32'h80000000, 32'h7FFFFFFF, 32'h00050000, 32'h0004FFFF,
            32'h00026000, 32'h00025FFF, 32'h00010000, 32'h0000FFFF,
            32'hFFFDA000, 32'hFFFB0000, 32'hFFFFFFF9, 32'hFFFFFFF8};
    max_run = 0;
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < CH; k++)
        d[k*DW +: DW] = (i < 8) ? bnd[(i*4+k)%12] : $urandom;
      send(2'(i % 4), d);
    end
    n_chk++;
    if (cyc - c0 != 16) begin
      n_fail++; $display("FAIL stream_in cycles got=%0d exp=16", cyc - c0);
    end
    idle();
    drain();
    tick();
    n_chk++;
    if (max_run != 16) begin
      n_fail++; $display("FAIL stream_out run got=%0d exp=16", max_run);
    end
  endtask

  task automatic test_backpressure();
    beat_t held;
    bus.i_ready = 1'b0;
    send(2'd1, {4{32'hFFFD0000}});
    send(2'd2, {4{32'hFFFD0000}});
    bus.i_valid = 1'b1;
    bus.i_mode  = 2'd3;
    bus.i_data  = {32'h1, 32'hFFFA0000, 32'h00030000, 32'h0};
    held = bus.o_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (bus.o_ready !== 1'b0 || acc) begin
        n_fail++; $display("FAIL bp_ready got=%b exp=0", bus.o_ready);
      end
      n_chk++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== held) begin
        n_fail++;
        $display("FAIL bp_hold got=%b/%h exp=1/%h", bus.o_valid, bus.o_data, held);
      end
    end
    bus.i_ready = 1'b1;
    send(2'd3, {32'h1, 32'hFFFA0000, 32'h00030000, 32'h0});
    send(2'd0, {4{32'h12345678}});
    idle();
    drain();
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b1;
    send(2'd1, {4{32'h00020000}});
    send(2'd3, {4{32'hFFFF8000}});
    idle();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== '0) begin
      n_fail++;
      $display("FAIL mid_rst got=%b/%h exp=0/0", bus.o_valid, bus.o_data);
    end
    sb.delete();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (bus.o_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_idle%0d got=%b exp=0", i, bus.o_valid);
      end
    end
    send(2'd2, {4{32'hFFFFFF00}});
    idle();
    drain();
  endtask

  task automatic test_sat_cnt();
    beat_t s;
    s = {32'h00008000, 32'hFFFA0000, 32'h00010000, 32'h0};
`ifdef ACT_SAT_CNT_EN
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_chk++;
    if (sat_cnt !== 16'd0) begin
      n_fail++; $display("FAIL cnt_clr0 got=%h exp=0", sat_cnt);
    end
    for (int i = 0; i < 3; i++) send(2'd3, s);
    send(2'd3, {4{32'h00020000}});
    send(2'd1, {4{32'h00080000}});
    idle();
    drain();
    n_chk++;
    if (sat_cnt !== 16'd3) begin
      n_fail++; $display("FAIL cnt_three got=%h exp=3", sat_cnt);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_chk++;
    if (sat_cnt !== 16'd0) begin
      n_fail++; $display("FAIL cnt_clr got=%h exp=0", sat_cnt);
    end
    for (int i = 0; i < 65537; i++) send(2'd3, s);
    idle();
    drain();
    n_chk++;
    if (sat_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL cnt_sat got=%h exp=ffff", sat_cnt);
    end
`else
    for (int i = 0; i < 3; i++) send(2'd3, s);
    idle();
    drain();
    n_chk++;
    if (sat_cnt !== 16'd0) begin
      n_fail++; $display("FAIL cnt_off got=%h exp=0", sat_cnt);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sigmoid();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_sat_cnt();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
